// File: rtl/cursor_key_pulser.sv
// Debounced, auto-repeating one-hot direction pulses for the cursor cells.
// Each key has its own synchroniser and FSM; a lowest-index-first arbiter serialises the pulses.
module cursor_key_pulser #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SW_pause,
  input  logic [3:0] KEY_raw,
  output logic [3:0] KEY
);

  localparam int unsigned MaxDr  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                    : REPEAT_DELAY;
  localparam int unsigned MaxRs  = (REPEAT_RATE > SYNC_STAGES) ? REPEAT_RATE : SYNC_STAGES;
  localparam int unsigned MaxAll = (MaxDr > MaxRs) ? MaxDr : MaxRs;
  localparam int unsigned CntW   = $clog2(MaxAll + 1);

  localparam logic [CntW-1:0] DebCnt  = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] DlyCnt  = CntW'(REPEAT_DELAY);
  localparam logic [CntW-1:0] RateCnt = CntW'(REPEAT_RATE);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StDebPress,
    StHoldDly,
    StRepeat,
    StDebRel
  } state_e;

  logic [3:0]      sync_q [SYNC_STAGES];
  logic [3:0]      pressed;
  state_e          st_q   [4];
  state_e          st_d   [4];
  logic [CntW-1:0] cnt_q  [4];
  logic [CntW-1:0] cnt_d  [4];
  logic [3:0]      req;
  logic [3:0]      pending_q, pending_d;
  logic [3:0]      grant;
  logic [3:0]      key_d;

  // Buttons are active-low; the synchroniser idles at 1 so reset looks like "released".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 4'hF;
    end else begin
      sync_q[0] <= KEY_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign pressed = ~sync_q[SYNC_STAGES-1];

  always_comb begin
    req = 4'b0;
    for (int i = 0; i < 4; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        StIdle: begin
          if (pressed[i]) begin
            st_d[i]  = StDebPress;
            cnt_d[i] = OneCnt;
          end
        end
        StDebPress: begin
          if (!pressed[i]) begin
            st_d[i]  = StIdle;
            cnt_d[i] = '0;
          end else if (cnt_q[i] + OneCnt == DebCnt) begin
            req[i]   = 1'b1;
            st_d[i]  = StHoldDly;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + OneCnt;
          end
        end
        StHoldDly: begin
          if (!pressed[i]) begin
            st_d[i]  = StDebRel;
            cnt_d[i] = OneCnt;
          end else if (cnt_q[i] + OneCnt == DlyCnt) begin
            req[i]   = 1'b1;
            st_d[i]  = StRepeat;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + OneCnt;
          end
        end
        StRepeat: begin
          if (!pressed[i]) begin
            st_d[i]  = StDebRel;
            cnt_d[i] = OneCnt;
          end else if (cnt_q[i] + OneCnt == RateCnt) begin
            req[i]   = 1'b1;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + OneCnt;
          end
        end
        StDebRel: begin
          // A bounce during release restarts the hold delay without a new pulse.
          if (pressed[i]) begin
            st_d[i]  = StHoldDly;
            cnt_d[i] = '0;
          end else if (cnt_q[i] + OneCnt == DebCnt) begin
            st_d[i]  = StIdle;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + OneCnt;
          end
        end
        default: begin
          st_d[i]  = StIdle;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Lowest set bit wins; pause drops everything outstanding but leaves the FSMs running.
  always_comb begin
    grant = pending_q & (~pending_q + 4'd1);
    if (SW_pause) begin
      pending_d = 4'b0;
      key_d     = 4'b0;
    end else begin
      pending_d = (pending_q & ~grant) | req;
      key_d     = grant;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= StIdle;
        cnt_q[i] <= '0;
      end
      pending_q <= 4'b0;
      KEY       <= 4'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pending_q <= pending_d;
      KEY       <= key_d;
    end
  end

endmodule
